wb_cmd_master: RTL

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_master_pkg.sv | 15 +
 rtl/wb_cmd_master_timeout.sv | 39 +++
 rtl/wb_cmd_master.sv | 134 +++++++++++++
 3 files changed

// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the Wishbone command master.
// State encodings and the default timeout read-back value.
package wb_cmd_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    localparam int CNT_W = 16;

endpackage

// File: rtl/wb_cmd_master_timeout.sv
// Bus-cycle watchdog: counts stalled cycles and flags the last allowed one.
// expired is high while the count sits at LIMIT-1.
module wb_timeout_ctr
    import wb_cmd_master_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding command to Wishbone classic bridge with timeout.
// One command in, one bus cycle, one response out.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o
);

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdat_q, rdat_d;
    logic        err_q, err_d;

    logic accept;
    logic in_bus;
    logic expired;

    assign in_bus = (state_q == ST_BUS);
    assign accept = (state_q == ST_IDLE) && cmd_valid_i;

    wb_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .clr     (accept),
        .en      (in_bus && !wbm_ack_i),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // A late ack beats the watchdog.
                if (wbm_ack_i) begin
                    rdat_d  = we_q ? 32'h0 : wbm_dat_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (expired) begin
                    rdat_d  = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cyc_d = (state_d == ST_BUS);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE) && !wb_rst_i;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_dat_o   = rdat_q;
    assign rsp_err_o   = err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
